// File: rtl/div_pkg.sv
// Shared types and helpers for the RV32M divide/remainder sequencer.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV  = OP_DIV,
        DIVU = OP_DIVU,
        REM  = OP_REM,
        REMU = OP_REMU
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    function automatic logic op_is_signed(div_op_t o);
        return (o == DIV) || (o == REM);
    endfunction

    function automatic logic op_is_rem(div_op_t o);
        return (o == REM) || (o == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, record the quotient bit.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] q_next
);

    // The extra top bit keeps the shifted-out remainder MSB, so divisors
    // above 2^(W-1) still divide correctly.
    logic [DATA_WIDTH:0] trial;
    logic [DATA_WIDTH:0] diff;

    assign trial    = {rem, q[DATA_WIDTH-1]};
    assign diff     = trial - {1'b0, divisor};
    assign q_next   = {q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    assign rem_next = diff[DATA_WIDTH] ? trial[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Iterative DIV/DIVU/REM/REMU sequencer for the execute stage, one bit per cycle.
// Define DIV_ZERO_FAST_EN to finish divide-by-zero in a single cycle.
module div_sequencer
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  flush,
    output logic                  stall_E,
    output logic                  busy,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
`ifdef DIV_ZERO_FAST_EN
    localparam logic FAST_ZERO = 1'b1;
`else
    localparam logic FAST_ZERO = 1'b0;
`endif

    div_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    div_op_t               op_q, op_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] rem_next, quo_next;
    div_op_t               op_in;
    logic                  accept, zero_div, dvd_neg, dvs_neg, last_step;

    assign op_in     = div_op_t'(op);
    assign accept    = (state_q == IDLE) && start && !flush;
    assign zero_div  = (divisor == '0);
    assign dvd_neg   = op_is_signed(op_in) && dividend[DATA_WIDTH-1];
    assign dvs_neg   = op_is_signed(op_in) && divisor[DATA_WIDTH-1];
    assign last_step = (state_q == BUSY) && (cnt_q == CNT_LAST) && !flush;

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem      (rem_q),
        .q        (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_next),
        .q_next   (quo_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (FAST_ZERO && zero_div) ? DONE : BUSY;
            BUSY: if (flush) state_d = IDLE;
                  else if (cnt_q == CNT_LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        result_valid = (state_q == DONE) && !flush;
        stall_E      = rst_n && (accept || (state_q == BUSY));
    end

    // Quotient sign is suppressed on divide-by-zero so DIV always yields -1.
    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        result_d  = result_q;
        if (accept) begin
            op_d      = op_in;
            neg_quo_d = (dvd_neg ^ dvs_neg) && !zero_div;
            neg_rem_d = dvd_neg;
            quo_d     = dvd_neg ? -dividend : dividend;
            dvsr_d    = dvs_neg ? -divisor : divisor;
            rem_d     = '0;
            cnt_d     = '0;
            if (FAST_ZERO && zero_div) begin
                result_d = op_is_rem(op_in) ? dividend : '1;
            end
        end else if (state_q == BUSY) begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q + 1'b1;
            if (last_step) begin
                if (op_is_rem(op_q)) result_d = neg_rem_q ? -rem_next : rem_next;
                else                 result_d = neg_quo_q ? -quo_next : quo_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed table, random ops against an
// arithmetic reference, plus flush, reset and back-to-back sequences.
module tb_div_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         flush = 1'b0;
    logic         stall_E, busy, result_valid;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_res = '0;

    div_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .stall_E      (stall_E),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // RV32M results from plain 64-bit arithmetic.
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        case (o)
            2'b00: r = (b == 0) ? -1 : sa / sb;
            2'b01: r = (b == 0) ? -1 : longint'(a / b);
            2'b10: r = (b == 0) ? sa : sa % sb;
            default: r = (b == 0) ? sa : longint'(a % b);
        endcase
        return r[W-1:0];
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 0) ? 1 : W + 1;
`else
        return (b == 0) ? W + 1 : W + 1;
`endif
    endfunction

    // Entered and left at posedge+1. Operands are scrambled after acceptance.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input bit hold, input string nm);
        int cyc = 0;
        int stall_cnt = 0;
        bit seen = 0;
        start = 1'b1; op = o; dividend = a; divisor = b;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (result_valid) seen = 1;
            else begin
                if (stall_E) stall_cnt++;
                @(posedge clk); #1;
                dividend = $urandom; divisor = $urandom;
                cyc++;
            end
        end
        chk({nm, "_seen"}, W'(seen), W'(1));
        chk({nm, "_lat"}, W'(cyc), W'(exp_lat(b)));
        chk({nm, "_stall_cycles"}, W'(stall_cnt), W'(exp_lat(b)));
        chk({nm, "_result"}, result, exp);
        chk({nm, "_done_stall"}, W'(stall_E), W'(0));
        chk({nm, "_done_busy"}, W'(busy), W'(1));
        last_res = exp;
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
            chk({nm, "_pulse"}, W'(result_valid), W'(0));
            chk({nm, "_idle"}, W'(busy), W'(0));
            chk({nm, "_hold_res"}, result, exp);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t tbl[15];
        tbl[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
        tbl[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
        tbl[2]  = '{2'b00, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2};
        tbl[3]  = '{2'b10, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE};
        tbl[4]  = '{2'b10, 32'd100,        32'hFFFFFFF9,   32'd2};
        tbl[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF};
        tbl[6]  = '{2'b11, 32'd5,          32'd0,          32'd5};
        tbl[7]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};
        tbl[8]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0};
        tbl[9]  = '{2'b00, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF};
        tbl[10] = '{2'b10, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB};
        tbl[11] = '{2'b01, 32'hFFFFFFFF,   32'h80000001,   32'd1};
        tbl[12] = '{2'b11, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE};
        tbl[13] = '{2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14};
        tbl[14] = '{2'b01, 32'd0,          32'd9,          32'd0};

        // Reset state, with start high to show stall_E is gated by reset.
        start = 1'b1;
        #12;
        chk("rst_stall", W'(stall_E), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_valid", W'(result_valid), W'(0));
        chk("rst_result", result, W'(0));
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Odd entries leave start high so the next op is issued right after DONE.
        for (int i = 0; i < 15; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, (i % 2) == 1, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            logic [1:0] o;
            logic [W-1:0] a, b;
            int sel;
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            else if (sel == 1) b = W'($urandom_range(1, 20));
            else if (sel == 2) begin a = 32'h80000000; b = '1; end
            else if (sel == 3) b = b >> $urandom_range(1, 30);
            run_op(o, a, b, model(o, a, b), $urandom_range(0, 1) == 1, $sformatf("rnd%0d", i));
        end

        // Flush in IDLE beats start.
        start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd3;
        @(negedge clk);
        chk("idle_flush_stall", W'(stall_E), W'(0));
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", W'(busy), W'(0));
        @(posedge clk); #1;

        // Flush in the 10th BUSY cycle aborts without a result.
        begin
            int pulses = 0;
            start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
            for (int i = 0; i < 11; i++) begin @(posedge clk); #1; end
            flush = 1'b1; start = 1'b0;
            @(negedge clk);
            chk("flush_valid", W'(result_valid), W'(0));
            @(posedge clk); #1;
            flush = 1'b0;
            @(negedge clk);
            chk("flush_busy", W'(busy), W'(0));
            chk("flush_stall", W'(stall_E), W'(0));
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (result_valid) pulses++;
            end
            chk("flush_no_valid", W'(pulses), W'(0));
            chk("flush_keep_res", result, last_res);
            @(posedge clk); #1;
            run_op(2'b11, 32'd1000, 32'd3, 32'd1, 1'b0, "after_flush");
        end

        // Asynchronous reset in the middle of BUSY.
        start = 1'b1; op = 2'b00; dividend = 32'd12345; divisor = 32'd11;
        for (int i = 0; i < 15; i++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_stall", W'(stall_E), W'(0));
        chk("midrst_valid", W'(result_valid), W'(0));
        chk("midrst_result", result, W'(0));
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b00, 32'd12345, 32'd11, 32'd1122, 1'b1, "after_rst");
        run_op(2'b10, 32'd12345, 32'd11, 32'd3, 1'b0, "b2b_rem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle iterative divide/remainder controller for the execute stage (RV32M DIV, DIVU, REM, REMU).
- Runs beside the single-cycle ALU and sequences a 1-bit-per-cycle restoring divider.
- Stalls the F/D/E pipeline registers until the result is ready, then presents the result for the E→M register.
- Honours pipeline flush (branch or jump taken in E) by aborting in-flight work.

Parameters:
- DATA_WIDTH, 32, operand/result width. Must be a power of two, ≥ 8.
- CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  E-stage holds a divide-class instruction; request to begin
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  DATA_WIDTH  rs1 value (forwarded RD1)
- divisor  in  DATA_WIDTH  rs2 value (forwarded RD2)
- flush  in  1  synchronous abort (PCsrc_E taken, or higher-priority flush)
- stall_E  out  1  freeze PC, F/D and D/E registers; hold E operands
- busy  out  1  sequencer not IDLE
- result_valid  out  1  one-cycle pulse; result is valid
- result  out  DATA_WIDTH  quotient or remainder, selected by latched op

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, result=0, result_valid=0, busy=0, internal regs=0. stall_E=0 while in reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE, start=1, flush=0:
  - Latch op, operand signs, |dividend|, |divisor| (signed ops only; unsigned taken as-is).
  - Clear partial remainder; counter=0; go to BUSY.
- stall_E = (IDLE & start & ~flush) | BUSY. Combinational, so the issuing instruction holds in E from its first cycle.
- BUSY, each cycle:
  - One restoring step: rem = {rem[W-2:0], q[W-1]}, q <<= 1, trial subtract divisor, set q[0] on no-borrow.
  - counter++. On counter == DATA_WIDTH-1, go to DONE.
  - BUSY lasts exactly DATA_WIDTH cycles.
- BUSY→DONE transition: write result register.
  - DIV/DIVU: quotient, negated if signed op and dividend/divisor signs differ.
  - REM/REMU: remainder, negated if signed op and dividend negative.
- DONE: result_valid=1, busy=1, stall_E=0 (E→M captures result this cycle). Next state IDLE unconditionally; start ignored in DONE.
- Latency: start sampled at cycle 0, result_valid at cycle DATA_WIDTH+1 (33 for W=32).
- result holds its value after DONE until the next DONE. result_valid is a single-cycle pulse.
- Divide by zero, all ops via the natural algorithm:
  - DIVU quotient = all ones; DIV quotient = -1.
  - REM/REMU = dividend.
- Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0. Falls out of abs/negate in DATA_WIDTH bits; no special case needed.
- flush=1 in any state: next state IDLE, no result_valid, result register unchanged. In IDLE, flush has priority over start.
- Reset mid-operation: immediate return to reset values; no partial result emitted.
- Operand changes on dividend/divisor after acceptance are ignored (latched).

Optional Feature:
- DIV_ZERO_FAST_EN defined: in IDLE with start and divisor==0, go directly to DONE. The result register is written with the divide-by-zero values above. Latency is 1 cycle (result_valid at cycle 1), and stall_E is asserted only in the start cycle.
- Undefined: divide-by-zero runs the full DATA_WIDTH iterations. Results are bit-identical either way; only latency differs.

Decomposition:
- Package div_pkg holds:
  - div_op_t enum (DIV, DIVU, REM, REMU)
  - div_state_t enum (IDLE, BUSY, DONE)
  - OP_* localparams matching funct3[1:0]
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, q, divisor.
  - Outputs: rem_next, q_next.
  - Unit-tested separately.
- The FSM, counter, sign handling and result mux stay in div_sequencer.

Test Plan:
- DIVU 100/7: start at cycle 0 → stall_E=1 for cycles 0..32, result_valid at cycle 33, result=14; REMU same operands → 2.
- DIV -100/7 → -14 (0xFFFFFFF2); REM -100/7 → -2 (0xFFFFFFFE); REM 100/-7 → 2.
- Divide by zero, DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5. Latency 33 cycles without DIV_ZERO_FAST_EN, 1 cycle with it.
- Overflow DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- flush at cycle 10 of BUSY → IDLE at cycle 11, no result_valid, stall_E=0, previous result retained. A new start at cycle 12 completes normally.
- rst_n pulsed low mid-BUSY → busy, stall_E and result_valid drop immediately, result=0. Also check back-to-back divides: second start accepted in the cycle after DONE.
